// File: rtl/test_result_pkg.sv
// Shared word layout for the case-decode result capture path.
package test_result_pkg;

    localparam int WORD_W = 8;
    localparam int V_BIT  = 0;
    localparam int W_BIT  = 1;
    localparam int X_BIT  = 2;
    localparam int Y_BIT  = 3;
    localparam int Z_LSB  = 4;
    localparam int Z_W    = 4;

    function automatic logic [WORD_W-1:0] pack_result(
        input logic           v,
        input logic           w,
        input logic           x,
        input logic           y,
        input logic [Z_W-1:0] z
    );
        logic [WORD_W-1:0] r;
        r = '0;
        r[V_BIT] = v;
        r[W_BIT] = w;
        r[X_BIT] = x;
        r[Y_BIT] = y;
        r[Z_LSB +: Z_W] = z;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/test_result_fifo.sv
// Packs producer outputs into result words and buffers them for a consumer.
// Optional change filter: TEST_RESULT_FIFO_CHANGE_FILTER_EN.
module test_result_fifo
    import test_result_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       v,
    input  logic                       w,
    input  logic                       x,
    input  logic                       y,
    input  logic [3:0]                 z,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       drop_flag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              drop_flag_q, drop_flag_d;

    logic [WORD_W-1:0] word;
    logic              offer;
    logic              push;
    logic              pop;
    logic              drop;

    assign word = pack_result(v, w, x, y, z);

`ifdef TEST_RESULT_FIFO_CHANGE_FILTER_EN
    logic [WORD_W-1:0] last_word_q;
    logic              last_vld_q;

    // Repeats of the last accepted word are not offered at all.
    assign offer = in_valid && !(last_vld_q && (word == last_word_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_word_q <= '0;
            last_vld_q  <= 1'b0;
        end else if (push) begin
            last_word_q <= word;
            last_vld_q  <= 1'b1;
        end
    end
`else
    assign offer = in_valid;
`endif

    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = offer && (!full || pop);
    assign drop      = offer && full && !pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        drop_flag_d = drop_flag_q || drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_flag_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_flag_q <= drop_flag_d;
        end
    end

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    sat_counter #(
        .W(DROP_W)
    ) u_drop_cnt (
        .clk  (clk),
        .clr_i(rst),
        .inc_i(drop && !rst),
        .cnt_o(drop_cnt)
    );

    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign drop_flag = drop_flag_q;

endmodule
